// File: rtl/interval_timer_ctrl.sv
// interval_timer_ctrl
//   Sequencer for an external up-counter that produces a train of equal
//   periods. On start it latches a preload value P and a repetition count.
//   It loads the counter once, then lets it count up to all ones. Each
//   terminal count produces a tick. The counter is reloaded for the next
//   repetition, or the sequence finishes with a done pulse.
//   A repetition count of 0 runs until stop.
//
// Parameters
//   CNT_W      width of the external counter, period_in and ctr_in
//   REP_W      width of reps_in and rep_left
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      begin a sequence (honoured in IDLE only)
//   stop       abort the sequence from LOAD or RUN
//   pause      freeze counting while in RUN
//   period_in  preload value P
//   reps_in    number of periods, 0 = continuous
//   tcount     terminal-count flag from the counter (count is all ones)
//   ctr_in     preload value driven to the counter
//   ctr_ld     counter load enable
//   ctr_cnt    counter count enable
//   busy       high in LOAD and RUN
//   tick       one-cycle pulse after each completed period
//   done       one-cycle pulse on normal completion
//   rep_left   repetitions still to run
module interval_timer_ctrl #(
  parameter int CNT_W = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic [CNT_W-1:0] period_in,
  input  logic [REP_W-1:0] reps_in,
  input  logic             tcount,
  output logic [CNT_W-1:0] ctr_in,
  output logic             ctr_ld,
  output logic             ctr_cnt,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [REP_W-1:0] rep_left
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] ctr_in_q, ctr_in_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic             tick_q, tick_d;

  // State registers. Reset is asynchronous, so every output derived from
  // these registers drops without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ctr_in_q   <= '0;
      rep_left_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctr_in_q   <= ctr_in_d;
      rep_left_q <= rep_left_d;
      tick_q     <= tick_d;
    end
  end

  // Next-state and counter-control logic.
  // In RUN, rep_left can only be 0 when the sequence was started with
  // reps_in = 0, because the last finite repetition leaves RUN as it
  // clears rep_left. This makes rep_left = 0 the continuous-mode flag.
  // The tick is registered, so it appears in the cycle after the terminal
  // count. On the last repetition that cycle is DONE, which makes the
  // final tick and done coincide.
  always_comb begin
    state_d    = state_q;
    ctr_in_d   = ctr_in_q;
    rep_left_d = rep_left_q;
    tick_d     = 1'b0;
    ctr_ld     = 1'b0;
    ctr_cnt    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          ctr_in_d   = period_in;
          rep_left_d = reps_in;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        if (stop) begin
          state_d = IDLE;
        end else begin
          ctr_ld  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (pause) begin
          state_d = RUN;
        end else if (!tcount) begin
          ctr_cnt = 1'b1;
        end else begin
          tick_d = 1'b1;
          if (rep_left_q == '0) begin
            ctr_ld = 1'b1;
          end else if (rep_left_q > REP_W'(1)) begin
            ctr_ld     = 1'b1;
            rep_left_d = rep_left_q - REP_W'(1);
          end else begin
            rep_left_d = '0;
            state_d    = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ctr_in   = ctr_in_q;
  assign rep_left = rep_left_q;
  assign tick     = tick_q;
  assign done     = (state_q == DONE);
  assign busy     = (state_q == LOAD) || (state_q == RUN);

endmodule

// File: tb/tb_interval_timer_ctrl.sv
// tb_interval_timer_ctrl
//   Directed bench for interval_timer_ctrl. A 4-bit up-counter is attached
//   to the controller. Each cycle of a sequence is compared against
//   hand-computed flag vectors.
//   Flag vector layout: {busy, ctr_ld, ctr_cnt, tick, done}.
module tb_interval_timer_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic [3:0] period_in;
  logic [3:0] reps_in;
  logic       tcount;
  logic [3:0] ctr_in;
  logic       ctr_ld;
  logic       ctr_cnt;
  logic       busy;
  logic       tick;
  logic       done;
  logic [3:0] rep_left;

  logic [3:0] cnt;

  int total;
  int bad;

  logic [4:0] expA [10];
  logic [4:0] expB [5];
  logic [4:0] expC [9];

  interval_timer_ctrl #(.CNT_W(4), .REP_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .pause     (pause),
    .period_in (period_in),
    .reps_in   (reps_in),
    .tcount    (tcount),
    .ctr_in    (ctr_in),
    .ctr_ld    (ctr_ld),
    .ctr_cnt   (ctr_cnt),
    .busy      (busy),
    .tick      (tick),
    .done      (done),
    .rep_left  (rep_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter driven by the controller. A load takes priority over a count.
  always @(posedge clk or negedge rst) begin
    if (!rst) cnt <= 4'd0;
    else if (ctr_ld) cnt <= ctr_in;
    else if (ctr_cnt) cnt <= cnt + 4'd1;
  end
  assign tcount = (cnt == 4'hF);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic sp, input logic p,
                               input logic [3:0] per, input logic [3:0] rp);
    start     = s;
    stop      = sp;
    pause     = p;
    period_in = per;
    reps_in   = rp;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] flags();
    return {27'd0, busy, ctr_ld, ctr_cnt, tick, done};
  endfunction

  // Load and count enables must never be high together.
  always @(negedge clk) begin
    checkOutput("ld_cnt_exclusive", {31'd0, ctr_ld & ctr_cnt}, 32'd0);
  end

  initial begin
    int hiCnt;
    int busyCnt;
    int tickCnt;
    int doneCnt;
    total = 0;
    bad   = 0;
    expA = '{5'h14, 5'h14, 5'h14, 5'h18, 5'h16, 5'h14, 5'h14, 5'h10, 5'h03, 5'h00};
    expB = '{5'h18, 5'h1A, 5'h12, 5'h00, 5'h00};
    expC = '{5'h14, 5'h10, 5'h10, 5'h10, 5'h14, 5'h14, 5'h10, 5'h03, 5'h00};

    rst = 1'b1;
    start = 1'b0; stop = 1'b0; pause = 1'b0;
    period_in = 4'd0; reps_in = 4'd0;
    #2 rst = 1'b0;
    #1;
    checkOutput("reset_flags", flags(), 32'h0);
    checkOutput("reset_ctr_in", {28'd0, ctr_in}, 32'd0);
    checkOutput("reset_rep_left", {28'd0, rep_left}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // P=12, reps=2: period of 4, done together with the second tick.
    nextCycle(); applyStimulus(1, 0, 0, 4'd12, 4'd2);
    checkOutput("A_idle", flags(), 32'h00);
    nextCycle(); applyStimulus(0, 0, 0, 4'd12, 4'd2);
    checkOutput("A_load", flags(), 32'h18);
    checkOutput("A_ctr_in", {28'd0, ctr_in}, 32'd12);
    checkOutput("A_rep_load", {28'd0, rep_left}, 32'd2);
    for (int i = 0; i < 10; i++) begin
      nextCycle(); applyStimulus(0, 0, 0, 4'd12, 4'd2);
      checkOutput($sformatf("A_c%0d", i + 1), flags(), {27'd0, expA[i]});
      if (i == 4) checkOutput("A_rep_mid", {28'd0, rep_left}, 32'd1);
      if (i == 8) checkOutput("A_rep_end", {28'd0, rep_left}, 32'd0);
    end

    // P=15, reps=0: every RUN cycle is terminal; stop ends it with no done.
    nextCycle(); applyStimulus(1, 0, 0, 4'd15, 4'd0);
    nextCycle(); applyStimulus(0, 0, 0, 4'd15, 4'd0);
    checkOutput("B_load", flags(), 32'h18);
    for (int i = 0; i < 5; i++) begin
      nextCycle(); applyStimulus(0, (i == 2), 0, 4'd15, 4'd0);
      if (i == 2) checkOutput("B_stop", flags() & 32'h1D, {27'd0, expB[i]} & 32'h1D);
      else        checkOutput($sformatf("B_c%0d", i + 1), flags(), {27'd0, expB[i]});
      if (i == 0) checkOutput("B_rep", {28'd0, rep_left}, 32'd0);
    end

    // P=12, reps=1, pause for 3 cycles at count 13: the tick slips by 3.
    nextCycle(); applyStimulus(1, 0, 0, 4'd12, 4'd1);
    nextCycle(); applyStimulus(0, 0, 0, 4'd12, 4'd1);
    checkOutput("C_load", flags(), 32'h18);
    for (int i = 0; i < 9; i++) begin
      nextCycle(); applyStimulus(0, 0, (i >= 1 && i <= 3), 4'd12, 4'd1);
      checkOutput($sformatf("C_c%0d", i + 1), flags(), {27'd0, expC[i]});
      if (i == 3) checkOutput("C_cnt_hold", {28'd0, cnt}, 32'd13);
      if (i == 3) checkOutput("C_rep_hold", {28'd0, rep_left}, 32'd1);
      if (i == 4) checkOutput("C_cnt_resume", {28'd0, cnt}, 32'd13);
    end

    // Restart while busy is ignored; stop on the terminal cycle wins.
    nextCycle(); applyStimulus(1, 0, 0, 4'd12, 4'd3);
    nextCycle(); applyStimulus(0, 0, 0, 4'd12, 4'd3);
    checkOutput("D_load_ctr_in", {28'd0, ctr_in}, 32'd12);
    checkOutput("D_load_rep", {28'd0, rep_left}, 32'd3);
    nextCycle(); applyStimulus(1, 0, 0, 4'd5, 4'd7);
    checkOutput("D_c1", flags(), 32'h14);
    nextCycle(); applyStimulus(0, 0, 0, 4'd5, 4'd7);
    checkOutput("D_ign_ctr_in", {28'd0, ctr_in}, 32'd12);
    checkOutput("D_ign_rep", {28'd0, rep_left}, 32'd3);
    nextCycle(); applyStimulus(0, 0, 0, 4'd5, 4'd7);
    checkOutput("D_c3", flags(), 32'h14);
    nextCycle(); applyStimulus(0, 1, 0, 4'd5, 4'd7);
    checkOutput("D_term_cnt", {28'd0, cnt}, 32'd15);
    checkOutput("D_stop", flags(), 32'h10);
    nextCycle(); applyStimulus(0, 0, 0, 4'd5, 4'd7);
    checkOutput("D_after_stop", flags(), 32'h00);
    checkOutput("D_after_rep", {28'd0, rep_left}, 32'd3);
    nextCycle();
    checkOutput("D_after2", flags(), 32'h00);
    checkOutput("D_after_ctr_in", {28'd0, ctr_in}, 32'd12);

    // P=0, reps=1: 16 RUN cycles, 15 of them counting, then done.
    nextCycle(); applyStimulus(1, 0, 0, 4'd0, 4'd1);
    nextCycle(); applyStimulus(0, 0, 0, 4'd0, 4'd1);
    checkOutput("E_load", flags(), 32'h18);
    hiCnt = 0; busyCnt = 0; tickCnt = 0; doneCnt = 0;
    for (int i = 0; i < 16; i++) begin
      nextCycle(); #1;
      hiCnt   += int'(ctr_cnt);
      busyCnt += int'(busy);
      tickCnt += int'(tick);
      doneCnt += int'(done);
    end
    checkOutput("E_cnt_cycles", hiCnt, 32'd15);
    checkOutput("E_run_cycles", busyCnt, 32'd16);
    checkOutput("E_early_tick", tickCnt, 32'd0);
    checkOutput("E_early_done", doneCnt, 32'd0);
    nextCycle(); #1;
    checkOutput("E_done", flags(), 32'h03);
    nextCycle(); #1;
    checkOutput("E_idle", flags(), 32'h00);

    // Reset in RUN at count 13 clears everything at once, then a fresh run.
    nextCycle(); applyStimulus(1, 0, 0, 4'd12, 4'd0);
    nextCycle(); applyStimulus(0, 0, 0, 4'd12, 4'd0);
    nextCycle(); #1;
    nextCycle(); #1;
    checkOutput("F_cnt13", {28'd0, cnt}, 32'd13);
    #1 rst = 1'b0;
    #1;
    checkOutput("F_reset_all", {19'd0, ctr_in, rep_left, busy, ctr_ld, ctr_cnt, tick, done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    nextCycle(); #1;
    checkOutput("F_busy_rel1", {31'd0, busy}, 32'd0);
    nextCycle(); applyStimulus(1, 0, 0, 4'd14, 4'd1);
    checkOutput("F_busy_rel2", {31'd0, busy}, 32'd0);
    nextCycle(); applyStimulus(0, 0, 0, 4'd14, 4'd1);
    checkOutput("F_load", flags(), 32'h18);
    checkOutput("F_ctr_in", {28'd0, ctr_in}, 32'd14);
    nextCycle(); #1;
    checkOutput("F_c1", flags(), 32'h14);
    nextCycle(); #1;
    checkOutput("F_c2", flags(), 32'h10);
    nextCycle(); #1;
    checkOutput("F_done", flags(), 32'h03);
    nextCycle(); #1;
    checkOutput("F_idle", flags(), 32'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/interval_timer_ctrl.md
INTERVAL_TIMER_CTRL -- requirements
Module: interval_timer_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  CNT_W, 4, width of the sequenced up-counter and of period_in/ctr_in.
  REP_W, 4, width of reps_in/rep_left.
REQ-002 Ports SHALL be, one per line:
  clk  input  1  sole clock; all state changes on rising edge.
  rst  input  1  asynchronous, active-low reset.
  start  input  1  begin a sequence (sampled in IDLE only).
  stop  input  1  abort the sequence.
  pause  input  1  freeze counting while in RUN.
  period_in  input  CNT_W  counter preload value P.
  reps_in  input  REP_W  repetition count; 0 = continuous.
  tcount  input  1  terminal-count flag from the counter (count = all ones).
  ctr_in  output  CNT_W  preload value driven to the counter.
  ctr_ld  output  1  counter load enable.
  ctr_cnt  output  1  counter count enable.
  busy  output  1  sequence in progress.
  tick  output  1  one-cycle pulse per completed period.
  done  output  1  one-cycle pulse at normal sequence completion.
  rep_left  output  REP_W  remaining repetitions.
REQ-003 One clock; reset is asynchronous and active-low, with the clock and reset ports named clk and rst.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, LOAD, RUN, DONE.
REQ-005 In IDLE with start=1, the block SHALL latch period_in into ctr_in and reps_in into rep_left, then enter LOAD.
REQ-006 LOAD SHALL last exactly one cycle with ctr_ld=1 and ctr_cnt=0, then enter RUN; pause is ignored in LOAD.
REQ-007 In RUN with pause=0 and tcount=0: ctr_cnt=1 and ctr_ld=0.
REQ-008 In RUN with pause=1: ctr_cnt=0 and ctr_ld=0; tcount is not acted on; state and rep_left hold.
REQ-009 In RUN with pause=0 and tcount=1 (terminal):
  - tick=1 in the following cycle.
  - ctr_cnt=0.
  - If reps_in was 0: ctr_ld=1 (reload); rep_left holds at 0; stay in RUN.
  - Else if rep_left>1: ctr_ld=1; rep_left decrements; stay in RUN.
  - Else (rep_left=1): ctr_ld=0; rep_left becomes 0; enter DONE.
REQ-010 Period SHALL be exactly 2^CNT_W - P cycles of RUN per repetition; for P=all ones, every RUN cycle is terminal.
REQ-011 DONE SHALL last one cycle with done=1, coincident with the final tick, and ctr_ld=ctr_cnt=0; it then enters IDLE.
REQ-012 busy SHALL be 1 in LOAD and RUN only.
REQ-013 ctr_ld and ctr_cnt SHALL never be 1 in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-014 stop=1 in LOAD or RUN SHALL force IDLE at the next edge, with ctr_ld=ctr_cnt=0 in that cycle and no tick or done.
REQ-015 stop SHALL take priority over terminal and pause; start SHALL take effect only in IDLE; stop in IDLE has no effect.
REQ-016 tick, done, ctr_ld and ctr_cnt SHALL be 0 in every cycle not named above.
REQ-017 ctr_in SHALL change only on a start accepted in IDLE.

Reset
REQ-018 rst=0 SHALL immediately, without a clock edge:
  - force IDLE;
  - clear ctr_in, rep_left, ctr_ld, ctr_cnt, busy, tick and done to 0.
REQ-019 Reset mid-sequence SHALL abandon the sequence with no done pulse; operation resumes on the first edge after rst=1 with a fresh start.

Verification
REQ-020 Assert rst=0 while in RUN at count=13 -> all outputs 0 immediately, before the next edge; busy stays 0 after release until start.
REQ-021 start with P=12, reps=2 and counter attached:
  - ctr_ld for 1 cycle with ctr_in=12;
  - tick pulses 4 cycles apart;
  - done coincides with the second tick;
  - busy=0 in the DONE cycle.
REQ-022 start with P=15, reps=0 -> tick every cycle after LOAD and no done; stop -> IDLE next edge, no further tick.
REQ-023 P=12, reps=1, pause held 3 cycles at count=13 -> count holds at 13 and the tick is delayed by exactly 3 cycles versus no pause.
REQ-024 Assert start while busy -> ignored (ctr_in and rep_left unchanged); assert stop in the same cycle as a terminal -> IDLE, no tick, no done.
REQ-025 P=0, reps=1 -> 16 RUN cycles with ctr_cnt high for 15 of them, then done=1 and tick=1 together, then IDLE.
